// File: rtl/sdram_read_responder_if.sv
// Row-fetch read handshake between the LED row fetcher (master) and the SDRAM read responder (slave).
// The fetcher drives readReq/address; the responder acks each address and returns words in order.
interface sdram_read_responder_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              readReq;
    logic [ADDR_W-1:0] address;
    logic              addressAck;
    logic              readDataValid;
    logic [DATA_W-1:0] readData;

    modport master (
        output readReq,
        output address,
        input  addressAck,
        input  readDataValid,
        input  readData
    );

    modport slave (
        input  readReq,
        input  address,
        output addressAck,
        output readDataValid,
        output readData
    );
endinterface

// File: rtl/sdram_read_responder.sv
// Responder for the LED row-fetch read handshake: forwards credited addresses to the SDRAM controller and returns data in order.
// Optional macro LED_RD_FLUSH_EN: responses arriving while draining are consumed but not forwarded.
module sdram_read_responder #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  SDRAM_CLK,
    input  logic                  nReset,
    sdram_read_responder_if.slave rdBus,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_W-1:0]     mem_cmd_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  busy,
    output logic                  protoErr
);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstandingNext;
    logic              creditOk;
    logic              cmdAccept;
    logic              rspAccepted;
    logic              readDataValidReg;
    logic [DATA_W-1:0] readDataReg;

    // A full window still issues when a response frees a slot in the same cycle,
    // so sustained throughput is not lost at the credit limit.
    always_comb begin
        creditOk      = (outstanding < MAX_CNT) || ((outstanding == MAX_CNT) && mem_rsp_valid);
        mem_cmd_valid = (state == ISSUE) && rdBus.readReq && creditOk;
        cmdAccept     = mem_cmd_valid && mem_cmd_ready;
        rspAccepted   = mem_rsp_valid && ((outstanding != '0) || cmdAccept);

        outstandingNext = outstanding;
        if (cmdAccept && !rspAccepted) begin
            outstandingNext = outstanding + 1'b1;
        end else if (!cmdAccept && rspAccepted) begin
            outstandingNext = outstanding - 1'b1;
        end
    end

    assign mem_cmd_addr        = rdBus.address;
    assign rdBus.addressAck    = cmdAccept;
    assign rdBus.readDataValid = readDataValidReg;
    assign rdBus.readData      = readDataReg;

    always_ff @(posedge SDRAM_CLK or negedge nReset) begin
        if (!nReset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            outstanding      <= '0;
            readDataValidReg <= 1'b0;
            readDataReg      <= '0;
            protoErr         <= 1'b0;
        end else begin
            outstanding <= outstandingNext;
            readDataReg <= mem_rsp_data;
`ifdef LED_RD_FLUSH_EN
            readDataValidReg <= rspAccepted && (state != DRAIN);
`else
            readDataValidReg <= rspAccepted;
`endif
            if (mem_rsp_valid && !rspAccepted) begin
                protoErr <= 1'b1;
            end

            // DRAIN ignores readReq until fully empty so bursts never interleave.
            case (state)
                IDLE: begin
                    if (rdBus.readReq) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!rdBus.readReq) begin
                        if (outstandingNext != '0) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (outstandingNext == '0) begin
                        if (rdBus.readReq) begin
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_read_responder.sv
// Scoreboard bench for sdram_read_responder: a bench controller model answers acked addresses,
// expected words are queued on ack and a separate monitor checks every returned word in order.
`timescale 1ns/1ps
module tb_sdram_read_responder;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int MAX_OUT = 8;
    localparam int LAT     = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } pend_t;

    logic              SDRAM_CLK     = 1'b0;
    logic              nReset        = 1'b0;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready = 1'b0;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data  = '0;
    logic              busy;
    logic              protoErr;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int ackCount = 0;
    int dataCount = 0;
    int rspCount = 0;
    int releaseCnt = 0;
    int strayCnt = 0;
    bit holdRsp = 1'b0;
    bit advance = 1'b0;
    logic [ADDR_W-1:0] addrReg = 24'h000100;

    pend_t             pendQ[$];
    logic [DATA_W-1:0] expQ[$];
    int                ackCycles[$];
    int                dataCycles[$];
    int                rspCycles[$];

    sdram_read_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rdBus ();

    sdram_read_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .SDRAM_CLK    (SDRAM_CLK),
        .nReset       (nReset),
        .rdBus        (rdBus.slave),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .busy         (busy),
        .protoErr     (protoErr)
    );

    always #5 SDRAM_CLK = ~SDRAM_CLK;

    function automatic logic [DATA_W-1:0] wordFor(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] low;
        low = addr[DATA_W-1:0];
        return DATA_W'(low * 16'd40503) ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SDRAM_CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit req, input bit ready);
        rdBus.readReq = req;
        mem_cmd_ready = ready;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 500) begin
            tick(1);
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic waitAcks(input int start, input int target);
        int n = 0;
        while ((ackCount - start) < target && n < 400) begin
            tick(1);
            n++;
        end
    endtask

    // Every leftover expected word means a response the DUT never delivered.
    task automatic settle(input string name);
        tick(3);
`ifdef LED_RD_FLUSH_EN
        expQ.delete();
`else
        checkOutput(name, 32'(expQ.size()), 32'd0);
`endif
    endtask

    // Controller and requester model: drives responses and advances the address after each ack.
    always begin
        @(posedge SDRAM_CLK);
        cycle++;
        #2;
        if (!nReset) begin
            pendQ.delete();
            mem_rsp_valid = 1'b0;
        end else begin
            if (advance) begin
                addrReg = addrReg + 1'b1;
                advance = 1'b0;
            end
            rdBus.address = addrReg;
            mem_rsp_valid = 1'b0;
            if (strayCnt > 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 16'hBEEF;
                strayCnt--;
            end else if (pendQ.size() > 0 && pendQ[0].due <= cycle && (!holdRsp || releaseCnt > 0)) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pendQ[0].data;
                void'(pendQ.pop_front());
                rspCount++;
                if (holdRsp) releaseCnt--;
            end
        end
    end

    always @(negedge SDRAM_CLK) begin
        if (nReset) begin
            if (mem_rsp_valid) rspCycles.push_back(cycle);
            if (rdBus.addressAck) begin
                checkOutput("cmdAddr", 32'(mem_cmd_addr), 32'(rdBus.address));
                pendQ.push_back('{data: wordFor(rdBus.address), due: cycle + LAT});
                expQ.push_back(wordFor(rdBus.address));
                ackCycles.push_back(cycle);
                ackCount++;
                advance = 1'b1;
            end
        end
    end

    always @(negedge SDRAM_CLK) begin
        if (nReset && rdBus.readDataValid) begin
            dataCount++;
            dataCycles.push_back(cycle);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedData actual=%0h expected=none", rdBus.readData);
            end else begin
                checkOutput("readData", 32'(rdBus.readData), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int start, startData, startRsp, aIdx, dIdx, rIdx, reqCycle, n;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkOutput("rstAck", 32'(rdBus.addressAck), 32'd0);
        checkOutput("rstCmdValid", 32'(mem_cmd_valid), 32'd0);
        checkOutput("rstDataValid", 32'(rdBus.readDataValid), 32'd0);
        checkOutput("rstData", 32'(rdBus.readData), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstProtoErr", 32'(protoErr), 32'd0);
        nReset = 1'b1;
        tick(2);

        $display("[TB] burst of 128, latency %0d", LAT);
        start = ackCount; startData = dataCount;
        aIdx = ackCycles.size(); dIdx = dataCycles.size();
        applyStimulus(1'b1, 1'b1);
        reqCycle = cycle;
        waitAcks(start, 128);
        applyStimulus(1'b0, 1'b1);
        checkOutput("burstAcks", 32'(ackCount - start), 32'd128);
        checkOutput("firstAckLatency",
                    32'((aIdx < ackCycles.size()) ? ackCycles[aIdx] - reqCycle : -1), 32'd1);
        checkOutput("ackBackToBack",
                    32'((aIdx + 127 < ackCycles.size()) ? ackCycles[aIdx+127] - ackCycles[aIdx] : -1), 32'd127);
        waitIdle("burstIdle");
        tick(2);
`ifndef LED_RD_FLUSH_EN
        checkOutput("burstData", 32'(dataCount - startData), 32'd128);
`endif
        checkOutput("firstDataLatency",
                    32'((dIdx < dataCycles.size() && aIdx < ackCycles.size()) ? dataCycles[dIdx] - ackCycles[aIdx] : -1), 32'd4);
        settle("burstLeftover");

        $display("[TB] credit limit with responses withheld");
        holdRsp = 1'b1;
        start = ackCount;
        applyStimulus(1'b1, 1'b1);
        tick(20);
        checkOutput("creditAcks", 32'(ackCount - start), 32'd8);
        checkOutput("creditStall", 32'(rdBus.addressAck), 32'd0);
        releaseCnt = 1;
        tick(4);
        checkOutput("creditReack", 32'(ackCount - start), 32'd9);
        checkOutput("reackSameCycle",
                    32'((ackCycles.size() > 0 && rspCycles.size() > 0) ? ackCycles[$] - rspCycles[$] : -1), 32'd0);
        applyStimulus(1'b0, 1'b1);
        holdRsp = 1'b0;
        waitIdle("creditIdle");
        settle("creditLeftover");

        $display("[TB] drop readReq with 5 outstanding");
        holdRsp = 1'b1;
        start = ackCount; startData = dataCount; startRsp = rspCount;
        applyStimulus(1'b1, 1'b1);
        waitAcks(start, 5);
        applyStimulus(1'b0, 1'b1);
        tick(3);
        checkOutput("drainAcks", 32'(ackCount - start), 32'd5);
        checkOutput("drainBusy", 32'(busy), 32'd1);
        holdRsp = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("drainRspAtIdle", 32'(rspCount - startRsp), 32'd5);
        tick(2);
`ifdef LED_RD_FLUSH_EN
        checkOutput("drainData", 32'(dataCount - startData), 32'd0);
`else
        checkOutput("drainData", 32'(dataCount - startData), 32'd5);
`endif
        settle("drainLeftover");

        $display("[TB] reassert readReq while draining 2");
        holdRsp = 1'b1;
        start = ackCount;
        applyStimulus(1'b1, 1'b1);
        waitAcks(start, 2);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        applyStimulus(1'b1, 1'b1);
        tick(4);
        checkOutput("drainNoAck", 32'(ackCount - start), 32'd2);
        releaseCnt = 1;
        tick(3);
        checkOutput("drainNoAckAfterOne", 32'(ackCount - start), 32'd2);
        rIdx = rspCycles.size(); aIdx = ackCycles.size();
        releaseCnt = 1;
        tick(3);
        checkOutput("reassertAckCycle",
                    32'((aIdx < ackCycles.size() && rIdx < rspCycles.size()) ? ackCycles[aIdx] - rspCycles[rIdx] : -1), 32'd1);
        applyStimulus(1'b0, 1'b1);
        holdRsp = 1'b0;
        waitIdle("reassertIdle");
        settle("reassertLeftover");

        $display("[TB] stray response while idle");
        checkOutput("protoErrClean", 32'(protoErr), 32'd0);
        startData = dataCount;
        strayCnt = 1;
        tick(3);
        checkOutput("strayNoData", 32'(dataCount - startData), 32'd0);
        checkOutput("strayProtoErr", 32'(protoErr), 32'd1);
        tick(10);
        checkOutput("protoErrSticky", 32'(protoErr), 32'd1);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 1'b1);
        tick(8);
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("midRstAck", 32'(rdBus.addressAck), 32'd0);
        checkOutput("midRstCmdValid", 32'(mem_cmd_valid), 32'd0);
        checkOutput("midRstDataValid", 32'(rdBus.readDataValid), 32'd0);
        checkOutput("midRstData", 32'(rdBus.readData), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstProtoErr", 32'(protoErr), 32'd0);
        checkOutput("midRstOutstanding", 32'(dut.outstanding), 32'd0);
        applyStimulus(1'b0, 1'b0);
        expQ.delete();
        tick(3);
        nReset = 1'b1;
        tick(5);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstProtoErr", 32'(protoErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
